// File: rtl/periph_apb_arbiter.sv
// Round-robin arbiter serialising NB_REQ APB requesters onto one peripheral APB segment.
// Define APB_ARB_TIMEOUT_EN to build the ACCESS-phase watchdog (TIMEOUT_CYCLES).
module periph_apb_arbiter #(
    parameter int NB_REQ         = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_REQ-1:0]                req_psel_i,
    input  logic [NB_REQ-1:0]                req_penable_i,
    input  logic [NB_REQ-1:0]                req_pwrite_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_paddr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0] req_pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]        req_prdata_o,
    output logic [NB_REQ-1:0]                req_pready_o,
    output logic [NB_REQ-1:0]                req_pslverr_o,
    output logic                             m_psel_o,
    output logic                             m_penable_o,
    output logic                             m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]        m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]        m_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]        m_prdata_i,
    input  logic                             m_pready_i,
    input  logic                             m_pslverr_i
);

    localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          rrPtr_q, rrPtr_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic                      reqFound;
    logic [IDX_W-1:0]          reqIdx;
    int                        candIdx;

    // The requester's own PENABLE carries no information the arbiter needs.
    logic                      unusedPenable;
    assign unusedPenable = ^req_penable_i;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timer_q, timer_d;
`else
    localparam int unusedTimeout = TIMEOUT_CYCLES;
`endif

    // Pick the first requesting index at or after the round-robin pointer, wrapping.
    always_comb begin
        reqFound = 1'b0;
        reqIdx   = '0;
        candIdx  = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            candIdx = int'(rrPtr_q) + i;
            if (candIdx >= NB_REQ) begin
                candIdx = candIdx - NB_REQ;
            end
            if (!reqFound && req_psel_i[IDX_W'(candIdx)]) begin
                reqFound = 1'b1;
                reqIdx   = IDX_W'(candIdx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rrPtr_d = rrPtr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (reqFound) begin
                    grant_d = reqIdx;
                    addr_d  = req_paddr_i[int'(reqIdx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    wdata_d = req_pwdata_i[int'(reqIdx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    write_d = req_pwrite_i[reqIdx];
                    rrPtr_d = (int'(reqIdx) == NB_REQ - 1) ? '0 : reqIdx + IDX_W'(1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
`ifdef APB_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready arriving in the expiry cycle takes precedence over the abort.
                if (m_pready_i) begin
                    rdata_d = write_q ? '0 : m_prdata_i;
                    err_d   = m_pslverr_i;
                    state_d = DONE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (timer_q == TIMEOUT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rrPtr_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rrPtr_q <= rrPtr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    // Every output decodes flops only, so no input reaches an output combinationally.
    assign m_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign m_penable_o = (state_q == ACCESS);
    assign m_pwrite_o  = write_q;
    assign m_paddr_o   = addr_q;
    assign m_pwdata_o  = wdata_q;
    assign req_prdata_o = (state_q == DONE) ? rdata_q : '0;

    always_comb begin
        req_pready_o  = '0;
        req_pslverr_o = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            req_pready_o[k]  = (state_q == DONE) && (int'(grant_q) == k);
            req_pslverr_o[k] = (state_q == DONE) && (int'(grant_q) == k) && err_q;
        end
    end

endmodule

// File: tb/tb_periph_apb_arbiter.sv
// Directed self-checking bench for periph_apb_arbiter with two requesters and a
// scripted peripheral (configurable wait states, error, or hang).
module tb_periph_apb_arbiter;

    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NB-1:0]   reqPsel    = '0;
    logic [NB-1:0]   reqPenable = '0;
    logic [NB-1:0]   reqPwrite  = '0;
    logic [NB*AW-1:0] reqPaddr  = '0;
    logic [NB*DW-1:0] reqPwdata = '0;
    logic [DW-1:0]   reqPrdata;
    logic [NB-1:0]   reqPready;
    logic [NB-1:0]   reqPslverr;
    logic            mPsel, mPenable, mPwrite;
    logic [AW-1:0]   mPaddr;
    logic [DW-1:0]   mPwdata;
    logic [DW-1:0]   mPrdata;
    logic            mPready, mPslverr;

    logic            periphHang = 1'b0;
    int              periphWait = 0;
    logic            periphErr  = 1'b0;
    logic [DW-1:0]   periphData = '0;
    int              accessCnt  = 0;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    periph_apb_arbiter #(
        .NB_REQ(NB),
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_psel_i(reqPsel),
        .req_penable_i(reqPenable),
        .req_pwrite_i(reqPwrite),
        .req_paddr_i(reqPaddr),
        .req_pwdata_i(reqPwdata),
        .req_prdata_o(reqPrdata),
        .req_pready_o(reqPready),
        .req_pslverr_o(reqPslverr),
        .m_psel_o(mPsel),
        .m_penable_o(mPenable),
        .m_pwrite_o(mPwrite),
        .m_paddr_o(mPaddr),
        .m_pwdata_o(mPwdata),
        .m_prdata_i(mPrdata),
        .m_pready_i(mPready),
        .m_pslverr_i(mPslverr)
    );

    // Scripted peripheral: ready after periphWait ACCESS cycles unless hung.
    assign mPready  = mPsel && mPenable && !periphHang && (accessCnt == periphWait);
    assign mPslverr = mPready && periphErr;
    assign mPrdata  = mPready ? periphData : 32'hBAD0_0BAD;

    always @(posedge clk or posedge rst) begin
        if (rst) accessCnt <= 0;
        else if (mPsel && mPenable && !mPready) accessCnt <= accessCnt + 1;
        else accessCnt <= 0;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reqPsel = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic waitResp(input int budget, output logic [NB-1:0] rdy,
                            output logic [AW-1:0] addrSeen, output int cycles);
        rdy = '0;
        addrSeen = '0;
        cycles = 0;
        while (rdy == '0 && cycles < budget) begin
            step();
            cycles++;
            if (mPsel && !mPenable) addrSeen = mPaddr;
            rdy = reqPready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checkCount++;
        if ({mPsel, mPenable, mPwrite} !== 3'b000)
            $display("[TB] FAIL reset_ctrl: got %b expected 000", {mPsel, mPenable, mPwrite});
        else passCount++;
        checkCount++;
        if ({reqPready, reqPslverr, reqPrdata, mPaddr, mPwdata} !== '0)
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {reqPready, reqPslverr, reqPrdata, mPaddr, mPwdata});
        else passCount++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        reqPaddr[0 +: AW] = 32'h1A10_4000;
        reqPwrite = '0;
        periphHang = 1'b0;
        periphWait = 0;
        periphErr  = 1'b0;
        periphData = 32'hDEAD_BEEF;
        reqPsel = 2'b01;
        checkCount++;
        if (mPsel !== 1'b0) $display("[TB] FAIL read_c0_psel: got %b expected 0", mPsel);
        else passCount++;
        step();
        checkCount++;
        if ({mPsel, mPenable, mPaddr} !== {2'b10, 32'h1A10_4000})
            $display("[TB] FAIL read_c1_setup: got %b%b %h expected 10 1a104000", mPsel, mPenable, mPaddr);
        else passCount++;
        step();
        checkCount++;
        if ({mPsel, mPenable} !== 2'b11)
            $display("[TB] FAIL read_c2_access: got %b%b expected 11", mPsel, mPenable);
        else passCount++;
        step();
        checkCount++;
        if ({mPsel, reqPready, reqPslverr} !== {1'b0, 2'b01, 2'b00})
            $display("[TB] FAIL read_c3_ready: got psel %b pready %b pslverr %b expected 0 01 00",
                     mPsel, reqPready, reqPslverr);
        else passCount++;
        checkCount++;
        if (reqPrdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL read_c3_data: got %h expected deadbeef", reqPrdata);
        else passCount++;
        reqPsel = '0;
        step();
        checkCount++;
        if (reqPready !== 2'b00) $display("[TB] FAIL read_c4_oneshot: got %b expected 00", reqPready);
        else passCount++;
    endtask

    task automatic test_round_robin();
        logic [NB-1:0] rdy;
        logic [AW-1:0] seen;
        int            cyc;
        logic [NB-1:0] expRdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [AW-1:0] expAddr [4] = '{32'h1A10_0000, 32'h1A10_1000, 32'h1A10_0000, 32'h1A10_1000};
        doReset();
        periphWait = 0;
        reqPaddr = {32'h1A10_1000, 32'h1A10_0000};
        for (int t = 0; t < 4; t++) begin
            if (t == 0 || t == 2) begin
                if (t == 2) step();
                reqPsel = 2'b11;
            end
            waitResp(20, rdy, seen, cyc);
            checkCount++;
            if (rdy !== expRdy[t])
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", t, rdy, expRdy[t]);
            else passCount++;
            checkCount++;
            if (seen !== expAddr[t])
                $display("[TB] FAIL rr_addr_%0d: got %h expected %h", t, seen, expAddr[t]);
            else passCount++;
            reqPsel = reqPsel & ~rdy;
        end
        step();
    endtask

    task automatic test_write_slverr();
        reqPaddr[AW +: AW]  = 32'h1A10_2000;
        reqPwdata[DW +: DW] = 32'h0000_00A5;
        reqPwrite  = 2'b10;
        periphWait = 3;
        periphErr  = 1'b1;
        periphData = 32'h1234_5678;
        reqPsel = 2'b10;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            if (cyc == 2) begin
                reqPwdata[DW +: DW] = 32'hFFFF_FFFF;
                reqPwrite = 2'b00;
            end
            checkCount++;
            if (reqPready[0] !== 1'b0)
                $display("[TB] FAIL wr_req0_idle_c%0d: got %b expected 0", cyc, reqPready[0]);
            else passCount++;
            if (cyc <= 5) begin
                checkCount++;
                if ({mPwrite, mPwdata, mPsel} !== {1'b1, 32'h0000_00A5, 1'b1})
                    $display("[TB] FAIL wr_data_c%0d: got %b %h %b expected 1 000000a5 1",
                             cyc, mPwrite, mPwdata, mPsel);
                else passCount++;
            end
        end
        checkCount++;
        if ({reqPready, reqPslverr, reqPrdata} !== {2'b10, 2'b10, 32'h0})
            $display("[TB] FAIL wr_c6_resp: got %b %b %h expected 10 10 00000000",
                     reqPready, reqPslverr, reqPrdata);
        else passCount++;
        reqPsel = '0;
        periphErr = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] rdy;
        logic [AW-1:0] seen;
        int            cyc;
        doReset();
        periphWait = 0;
        reqPwrite = '0;
        reqPsel = 2'b11;
        for (int t = 0; t < 4; t++) begin
            waitResp(20, rdy, seen, cyc);
            checkCount++;
            if (rdy !== ((t % 2 == 0) ? 2'b01 : 2'b10))
                $display("[TB] FAIL b2b_grant_%0d: got %b expected %b", t, rdy,
                         (t % 2 == 0) ? 2'b01 : 2'b10);
            else passCount++;
            checkCount++;
            if (cyc !== ((t == 0) ? 3 : 4))
                $display("[TB] FAIL b2b_interval_%0d: got %0d expected %0d", t, cyc, (t == 0) ? 3 : 4);
            else passCount++;
        end
        reqPsel = '0;
        step();
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        reqPwrite = '0;
        periphData = 32'hCAFE_F00D;
        for (int run = 0; run < 2; run++) begin
            periphHang = (run == 0);
            periphWait = 7;
            reqPsel = 2'b01;
            for (int cyc = 1; cyc <= 10; cyc++) begin
                step();
                if (cyc == 9) begin
                    checkCount++;
                    if ({mPsel, mPenable, reqPready} !== 4'b1100)
                        $display("[TB] FAIL to%0d_c9_access: got %b expected 1100", run,
                                 {mPsel, mPenable, reqPready});
                    else passCount++;
                end
            end
            checkCount++;
            if ({mPsel, reqPready, reqPslverr} !== {1'b0, 2'b01, (run == 0) ? 2'b01 : 2'b00})
                $display("[TB] FAIL to%0d_c10_resp: got %b %b %b", run, mPsel, reqPready, reqPslverr);
            else passCount++;
            checkCount++;
            if (reqPrdata !== ((run == 0) ? 32'h0 : 32'hCAFE_F00D))
                $display("[TB] FAIL to%0d_c10_data: got %h expected %h", run, reqPrdata,
                         (run == 0) ? 32'h0 : 32'hCAFE_F00D);
            else passCount++;
            reqPsel = '0;
            step();
        end
        periphHang = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        reqPwrite = '0;
        periphHang = 1'b1;
        reqPsel = 2'b01;
        for (int cyc = 0; cyc < 300; cyc++) step();
        checkCount++;
        if ({mPsel, mPenable, reqPready} !== 4'b1100)
            $display("[TB] FAIL no_timeout_wait: got %b expected 1100", {mPsel, mPenable, reqPready});
        else passCount++;
        doReset();
        periphHang = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [NB-1:0] rdy;
        logic [AW-1:0] seen;
        int            cyc;
        doReset();
        reqPwrite = '0;
        periphHang = 1'b1;
        reqPsel = 2'b01;
        step();
        step();
        step();
        checkCount++;
        if (mPenable !== 1'b1) $display("[TB] FAIL rstmid_in_access: got %b expected 1", mPenable);
        else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if ({mPsel, mPenable, reqPready} !== 4'b0000)
            $display("[TB] FAIL rstmid_async_drop: got %b expected 0000", {mPsel, mPenable, reqPready});
        else passCount++;
        step();
        rst = 1'b0;
        periphHang = 1'b0;
        periphWait = 0;
        reqPsel = 2'b11;
        waitResp(20, rdy, seen, cyc);
        checkCount++;
        if ({rdy, cyc[3:0]} !== {2'b01, 4'd3})
            $display("[TB] FAIL rstmid_regrant: got %b after %0d expected 01 after 3", rdy, cyc);
        else passCount++;
        reqPsel = '0;
        step();
    endtask

    initial begin
        $display("[TB] starting periph_apb_arbiter bench");
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_slverr();
        test_back_to_back();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
